// File: rtl/softmax_pkg.sv
// Shared definitions for the streaming softmax: controller states and
// the default vector length, data width and fixed-point format.
package softmax_pkg;

    localparam int N_DEF    = 8;
    localparam int W_DEF    = 16;
    localparam int FRAC_DEF = 12;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_EXP  = 3'd2,
        ST_LOG  = 3'd3,
        ST_OUT  = 3'd4
    } state_e;

endpackage

// File: rtl/exp2_approx.sv
// Combinational base-2 exponential: 2^t ~= (1 + frac(t)) >> -floor(t),
// saturating to 1.0 for t >= 0 and flushing to zero for very negative t.
module exp2_approx #(
    parameter int W    = 16,
    parameter int FRAC = 12,
    parameter int TW   = 20
) (
    input  logic signed [TW-1:0] t_i,
    output logic        [W-1:0]  e_o
);

    localparam int SHW = $clog2(FRAC + 2);
    localparam logic [TW-1:0] SH_MAX = TW'(FRAC + 1);
    localparam logic [W-1:0]  ONE_Q  = W'(1) << FRAC;

    logic signed [TW-1:0] int_s;
    logic        [TW-1:0] neg_s;
    logic        [FRAC:0] mant_s;

    assign int_s  = t_i >>> FRAC;
    assign neg_s  = -int_s;
    assign mant_s = {1'b1, t_i[FRAC-1:0]};

    // Select saturation, underflow or the shifted mantissa
    always_comb begin
        e_o = '0;
        if (!t_i[TW-1]) begin
            e_o = ONE_Q;
        end else if (neg_s > SH_MAX) begin
            e_o = '0;
        end else begin
            e_o = W'(mant_s >> neg_s[SHW-1:0]);
        end
    end

endmodule

// File: rtl/softmax_stream.sv
// Streaming softmax over N-element vectors: load and track max, compute
// exp2 terms and their sum, take a Mitchell log2, then stream normalised outputs.
module softmax_stream
    import softmax_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int W    = W_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic        [W-1:0] out_data,
    output logic                out_last,
    output logic                busy
);

    localparam int IW = $clog2(N);
    localparam int AW = W + IW;
    localparam int DW = W + 1;
    localparam int TW = W + 4;
    localparam int PW = $clog2(AW + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_e               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic signed [W-1:0]  max_q, max_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic signed [TW-1:0] l_q, l_d;
    logic signed [W-1:0]  x_q [N];
    logic [W-1:0]         e_q [N];
    logic                 x_we_s, e_we_s;

    logic signed [W-1:0]  sel_x_s;
    logic signed [DW-1:0] d_s;
    logic signed [TW-1:0] d_ext_s, t_base_s, t_sel_s, l_s;
    logic [W-1:0]         e_s, lag_s;
    logic [AW-1:0]        sum_s;
    logic [PW-1:0]        p_s;
    logic [AW+FRAC-1:0]   low_s;
    logic [FRAC-1:0]      m_s;

    // Exponent argument: t = d*(1 + 1/2 - 1/16) ~= d*log2(e); OUT also subtracts L
    assign sel_x_s  = x_q[idx_q];
    assign d_s      = {sel_x_s[W-1], sel_x_s} - {max_q[W-1], max_q};
    assign d_ext_s  = {{(TW-DW){d_s[DW-1]}}, d_s};
    assign t_base_s = d_ext_s + (d_ext_s >>> 1) - (d_ext_s >>> 4);
    assign t_sel_s  = (state_q == ST_OUT) ? (t_base_s - l_q) : t_base_s;

    exp2_approx #(
        .W    (W),
        .FRAC (FRAC),
        .TW   (TW)
    ) u_exp2 (
        .t_i (t_sel_s),
        .e_o (e_s)
    );

    // The sum trails the e_q writes by one slot; LOG folds in the last term
    assign lag_s = (idx_q != '0) ? e_q[idx_q - IW'(1)] : '0;
    assign sum_s = acc_q + AW'(e_q[N-1]);

    // Mitchell log2 of the completed sum
    always_comb begin
        p_s = '0;
        for (int k = 0; k < AW; k++) begin
            if (sum_s[k]) begin
                p_s = PW'(k);
            end else begin
                p_s = p_s;
            end
        end
        low_s = {sum_s & ~(AW'(1) << p_s), {FRAC{1'b0}}};
        m_s   = FRAC'(low_s >> p_s);
        l_s   = ((TW'(p_s) - TW'(FRAC)) <<< FRAC) + TW'(m_s);
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        max_d   = max_q;
        acc_d   = acc_q;
        l_d     = l_q;
        x_we_s  = 1'b0;
        e_we_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    x_we_s  = 1'b1;
                    max_d   = in_data;
                    acc_d   = '0;
                    idx_d   = IW'(1);
                    state_d = ST_LOAD;
                end else begin
                    idx_d = '0;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    x_we_s = 1'b1;
                    if (in_data > max_q) begin
                        max_d = in_data;
                    end else begin
                        max_d = max_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_EXP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_EXP: begin
                e_we_s = 1'b1;
                acc_d  = acc_q + AW'(lag_s);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ST_LOG;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_LOG: begin
                acc_d   = sum_s;
                l_d     = l_s;
                idx_d   = '0;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    // Datapath registers and element / exponential storage
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            max_q <= '0;
            acc_q <= '0;
            l_q   <= '0;
            for (int k = 0; k < N; k++) begin
                x_q[k] <= '0;
                e_q[k] <= '0;
            end
        end else if (en) begin
            idx_q <= idx_d;
            max_q <= max_d;
            acc_q <= acc_d;
            l_q   <= l_d;
            if (x_we_s) begin
                x_q[idx_q] <= in_data;
            end
            if (e_we_s) begin
                e_q[idx_q] <= e_s;
            end
        end
    end

    assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_OUT);
    assign out_last  = (state_q == ST_OUT) && (idx_q == LAST_IDX);
    assign out_data  = (state_q == ST_OUT) ? e_s : '0;
    assign busy      = (state_q != ST_IDLE);

endmodule
